// File: rtl/oscillator_trace_plotter.sv
`default_nettype none
// ============================================================================
//  Module   : oscillator_trace_plotter
//  Purpose  : Decimates the x1/x2 oscillator state stream and draws a
//             scrolling strip-chart into the VGA framebuffer write port.
//             Each capture erases one column, plots the two trace pixels
//             and then advances to the next column.
//  Ports    : CLOCK_50 / reset (async, active-high) / restart (sync)
//             x1, x2        - signed 2.16 positions
//             sample_valid  - one pulse per integration step
//             decim         - capture every decim-th step (0 and 1 = every)
//             vga_xCoord, vga_yCoord, vga_color, w_en / wr_ack - write port
//             busy          - high whenever a strip is being drawn
//             dropped       - saturating count of captures lost while busy
//  Revision : 1.0 - initial release
// ============================================================================
module oscillator_trace_plotter #(
  parameter int         SCREEN_W = 640,
  parameter int         SCREEN_H = 480,
  parameter logic [7:0] BG_COLOR = 8'h00,
  parameter logic [7:0] C1_COLOR = 8'hE0,
  parameter logic [7:0] C2_COLOR = 8'h1C
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        restart,
  input  logic [17:0] x1,
  input  logic [17:0] x2,
  input  logic        sample_valid,
  input  logic [15:0] decim,
  output logic [9:0]  vga_xCoord,
  output logic [8:0]  vga_yCoord,
  output logic [7:0]  vga_color,
  output logic        w_en,
  input  logic        wr_ack,
  output logic        busy,
  output logic [7:0]  dropped
);

  localparam logic [2:0] c_st_idle    = 3'd0;
  localparam logic [2:0] c_st_erase   = 3'd1;
  localparam logic [2:0] c_st_plot1   = 3'd2;
  localparam logic [2:0] c_st_plot2   = 3'd3;
  localparam logic [2:0] c_st_advance = 3'd4;

  localparam logic [9:0] c_col_last  = 10'(SCREEN_W - 1);
  localparam logic [8:0] c_row_last  = 9'(SCREEN_H - 1);
  localparam logic [8:0] c_row1_max  = 9'(SCREEN_H / 2 - 1);
  localparam logic [8:0] c_row2_min  = 9'(SCREEN_H / 2);
  // Trace centre lines and clamp limits in the signed 11-bit row domain.
  localparam logic signed [10:0] c_mid1    = 11'(SCREEN_H / 4);
  localparam logic signed [10:0] c_mid2    = 11'(3 * SCREEN_H / 4);
  localparam logic signed [10:0] c_hi1_s   = 11'(SCREEN_H / 2 - 1);
  localparam logic signed [10:0] c_lo2_s   = 11'(SCREEN_H / 2);
  localparam logic signed [10:0] c_hi2_s   = 11'(SCREEN_H - 1);

  logic [2:0]  r_state, w_state_n;
  logic [9:0]  r_col, w_col_n;
  logic [8:0]  r_row_cnt, w_row_cnt_n;
  logic [15:0] r_dcnt, w_dcnt_n;
  logic [17:0] r_x1, r_x2, w_x1_n, w_x2_n;
  logic [7:0]  w_dropped_n;

  logic [15:0] w_dlim, w_dinc;
  logic        w_capture, w_accept;

  logic signed [10:0] w_t1, w_t2, w_d1, w_d2;
  logic [8:0]  w_row1, w_row2;

  logic        w_wen_n, w_busy_n;
  logic [9:0]  w_xc_n;
  logic [8:0]  w_yc_n;
  logic [7:0]  w_color_n;

  // Capture detection. dcnt never exceeds 65534, so the increment cannot wrap.
  always_comb begin
    w_dlim    = (decim == 16'd0) ? 16'd1 : decim;
    w_dinc    = r_dcnt + 16'd1;
    w_capture = sample_valid && (w_dinc >= w_dlim);
    w_accept  = w_en & wr_ack;
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) r_state <= c_st_idle;
    else       r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    if (restart) begin
      w_state_n = c_st_idle;
    end else begin
      case (r_state)
        c_st_idle:    if (w_capture) w_state_n = c_st_erase;
        c_st_erase:   if (w_accept && r_row_cnt == c_row_last) w_state_n = c_st_plot1;
        c_st_plot1:   if (w_accept) w_state_n = c_st_plot2;
        c_st_plot2:   if (w_accept) w_state_n = c_st_advance;
        c_st_advance: w_state_n = c_st_idle;
        default:      w_state_n = c_st_idle;
      endcase
    end
  end

  // Outputs are registered, so they are derived from next-cycle values.
  always_comb begin
    w_wen_n   = 1'b0;
    w_xc_n    = w_col_n;
    w_yc_n    = 9'd0;
    w_color_n = 8'd0;
    w_busy_n  = (w_state_n != c_st_idle);
    case (w_state_n)
      c_st_erase: begin
        w_wen_n   = 1'b1;
        w_yc_n    = w_row_cnt_n;
        w_color_n = BG_COLOR;
      end
      c_st_plot1: begin
        w_wen_n   = 1'b1;
        w_yc_n    = w_row1;
        w_color_n = C1_COLOR;
      end
      c_st_plot2: begin
        w_wen_n   = 1'b1;
        w_yc_n    = w_row2;
        w_color_n = C2_COLOR;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------- datapath
  always_comb begin
    w_col_n     = r_col;
    w_row_cnt_n = r_row_cnt;
    w_x1_n      = r_x1;
    w_x2_n      = r_x2;
    w_dropped_n = dropped;
    w_dcnt_n    = sample_valid ? (w_capture ? 16'd0 : w_dinc) : r_dcnt;
    if (restart) begin
      // Restart overrides any same-cycle capture; the drop count survives.
      w_col_n     = 10'd0;
      w_row_cnt_n = 9'd0;
      w_x1_n      = 18'd0;
      w_x2_n      = 18'd0;
      w_dcnt_n    = 16'd0;
    end else begin
      if (w_capture) begin
        if (r_state == c_st_idle) begin
          w_x1_n      = x1;
          w_x2_n      = x2;
          w_row_cnt_n = 9'd0;
        end else if (dropped != 8'hFF) begin
          w_dropped_n = dropped + 8'd1;
        end
      end
      if (r_state == c_st_erase && w_accept)
        w_row_cnt_n = (r_row_cnt == c_row_last) ? 9'd0 : r_row_cnt + 9'd1;
      if (r_state == c_st_advance)
        w_col_n = (r_col == c_col_last) ? 10'd0 : r_col + 10'd1;
    end
  end

  // Row mapping: the top 8 bits of a 2.16 value are x >>> 10 (+-2.0 -> +-128).
  always_comb begin
    w_t1 = {{3{w_x1_n[17]}}, w_x1_n[17:10]};
    w_t2 = {{3{w_x2_n[17]}}, w_x2_n[17:10]};
    w_d1 = c_mid1 - w_t1;
    w_d2 = c_mid2 - w_t2;
    if (w_d1 < 11'sd0)        w_row1 = 9'd0;
    else if (w_d1 > c_hi1_s)  w_row1 = c_row1_max;
    else                      w_row1 = w_d1[8:0];
    if (w_d2 < c_lo2_s)       w_row2 = c_row2_min;
    else if (w_d2 > c_hi2_s)  w_row2 = c_row_last;
    else                      w_row2 = w_d2[8:0];
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_col     <= 10'd0;
      r_row_cnt <= 9'd0;
      r_dcnt    <= 16'd0;
      r_x1      <= 18'd0;
      r_x2      <= 18'd0;
    end else begin
      r_col     <= w_col_n;
      r_row_cnt <= w_row_cnt_n;
      r_dcnt    <= w_dcnt_n;
      r_x1      <= w_x1_n;
      r_x2      <= w_x2_n;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      vga_xCoord <= 10'd0;
      vga_yCoord <= 9'd0;
      vga_color  <= 8'd0;
      w_en       <= 1'b0;
      busy       <= 1'b0;
      dropped    <= 8'd0;
    end else begin
      vga_xCoord <= w_xc_n;
      vga_yCoord <= w_yc_n;
      vga_color  <= w_color_n;
      w_en       <= w_wen_n;
      busy       <= w_busy_n;
      dropped    <= w_dropped_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_oscillator_trace_plotter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_oscillator_trace_plotter
//  Purpose  : Self-checking bench for oscillator_trace_plotter. A strip-level
//             reference model predicts the ordered write stream, busy and
//             dropped; randomized inputs exercise decimation and back-pressure.
//             The DUT uses a narrow screen so column wrap is reached quickly.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_oscillator_trace_plotter;

  localparam int TB_W = 12;
  localparam int TB_H = 480;

  logic        CLOCK_50 = 1'b0;
  logic        reset, restart, sample_valid, wr_ack;
  logic [17:0] x1, x2;
  logic [15:0] decim;
  logic [9:0]  vga_xCoord;
  logic [8:0]  vga_yCoord;
  logic [7:0]  vga_color;
  logic        w_en, busy;
  logic [7:0]  dropped;

  oscillator_trace_plotter #(.SCREEN_W(TB_W), .SCREEN_H(TB_H)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .restart(restart),
    .x1(x1), .x2(x2), .sample_valid(sample_valid), .decim(decim),
    .vga_xCoord(vga_xCoord), .vga_yCoord(vga_yCoord), .vga_color(vga_color),
    .w_en(w_en), .wr_ack(wr_ack), .busy(busy), .dropped(dropped)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ------------------------------------------------------ reference model
  logic [26:0] m_q[$];      // pending writes {x, y, colour}, in order
  bit          m_adv;       // column-advance cycle pending
  int          m_col, m_dcnt, m_dropped;
  int          busy_cycles, max_x;
  logic [8:0]  last_y1, last_y2;

  function automatic logic [8:0] row_of(input logic [17:0] x, input int centre,
                                        input int lo, input int hi);
    int t, v;
    t = $signed(x);
    t = t >>> 10;
    v = centre - t;
    if (v < lo) v = lo;
    if (v > hi) v = hi;
    return 9'(v);
  endfunction

  task automatic model_reset(input bit keep_drop);
    m_q.delete();
    m_adv  = 0;
    m_col  = 0;
    m_dcnt = 0;
    if (!keep_drop) m_dropped = 0;
  endtask

  task automatic push_strip();
    for (int r = 0; r < TB_H; r++) m_q.push_back({10'(m_col), 9'(r), 8'h00});
    m_q.push_back({10'(m_col), row_of(x1, TB_H/4, 0, TB_H/2-1), 8'hE0});
    m_q.push_back({10'(m_col), row_of(x2, 3*TB_H/4, TB_H/2, TB_H-1), 8'h1C});
  endtask

  // One clock cycle: inputs already driven; observe, predict, advance, compare.
  task automatic cyc();
    bit acc, stall, pre_busy, cap, rs;
    logic [26:0] stall_val;
    int lim;
    rs  = restart;
    acc = w_en && wr_ack;
    if (acc) begin
      if (m_q.size() == 0) check("spurious_write", 1, 0);
      else check("write", {vga_xCoord, vga_yCoord, vga_color}, m_q[0]);
      if (vga_color == 8'hE0) last_y1 = vga_yCoord;
      if (vga_color == 8'h1C) last_y2 = vga_yCoord;
      if (int'(vga_xCoord) > max_x) max_x = vga_xCoord;
    end
    stall     = w_en && !wr_ack;
    stall_val = {vga_xCoord, vga_yCoord, vga_color};

    pre_busy = (m_q.size() != 0) || m_adv;
    lim = (decim == 16'd0) ? 1 : int'(decim);
    cap = 0;
    if (sample_valid) begin
      if (m_dcnt + 1 >= lim) begin cap = 1; m_dcnt = 0; end
      else m_dcnt++;
    end
    if (rs) begin
      model_reset(1);
    end else begin
      if (cap) begin
        if (!pre_busy) push_strip();
        else if (m_dropped < 255) m_dropped++;
      end
      if (m_adv) begin
        m_adv = 0;
        m_col = (m_col == TB_W - 1) ? 0 : m_col + 1;
      end else if (acc && pre_busy) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) m_adv = 1;
      end
    end

    @(posedge CLOCK_50); #1;
    if (stall && !rs) check("stall_hold", {w_en, vga_xCoord, vga_yCoord, vga_color}, {1'b1, stall_val});
    check("w_en", w_en, m_q.size() != 0);
    check("busy", busy, (m_q.size() != 0) || m_adv);
    check("dropped", dropped, m_dropped);
    if (busy) busy_cycles++;
  endtask

  task automatic capture_one(input logic [17:0] a, input logic [17:0] b);
    x1 = a; x2 = b; decim = 16'd1; sample_valid = 1'b1;
    cyc();
    sample_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (((m_q.size() != 0) || m_adv) && n < budget) begin cyc(); n++; end
    if ((m_q.size() != 0) || m_adv) check("idle_timeout", 0, 1);
  endtask

  initial begin
    bit found;
    reset = 1'b1; restart = 1'b0; sample_valid = 1'b0; wr_ack = 1'b1;
    x1 = '0; x2 = '0; decim = 16'd1;
    model_reset(0);
    busy_cycles = 0; max_x = 0; last_y1 = '0; last_y2 = '0;
    repeat (3) @(posedge CLOCK_50);
    #1;
    check("rst_x", vga_xCoord, 0);
    check("rst_y", vga_yCoord, 0);
    check("rst_color", vga_color, 0);
    check("rst_w_en", w_en, 0);
    check("rst_busy", busy, 0);
    check("rst_dropped", dropped, 0);
    reset = 1'b0;
    repeat (3) cyc();

    // Directed strip: -0.5 / +0.5 at column 0
    busy_cycles = 0;
    capture_one(18'h3_8000, 18'h0_8000);
    wait_idle(600);
    check("busy_len", busy_cycles, 483);
    check("plot1_row", last_y1, 152);
    check("plot2_row", last_y2, 328);

    // Clamped extremes, then zero
    capture_one(18'h1_FFFF, 18'h2_0000);
    wait_idle(600);
    check("clamp_row1", last_y1, 0);
    check("clamp_row2", last_y2, 479);
    capture_one(18'h0_0000, 18'h0_0000);
    wait_idle(600);
    check("zero_row1", last_y1, 120);
    check("zero_row2", last_y2, 360);

    // sample_valid every cycle: drops saturate at 255
    sample_valid = 1'b1; decim = 16'd1;
    repeat (490) begin x1 = 18'($urandom); x2 = 18'($urandom); cyc(); end
    check("drop_saturate", dropped, 255);
    sample_valid = 1'b0;
    wait_idle(600);

    // Randomized decimation, back-pressure and occasional restart
    for (int i = 0; i < 6000; i++) begin
      wr_ack       = 1'($urandom);
      sample_valid = ($urandom_range(0, 7) == 0);
      decim        = 16'($urandom_range(0, 3));
      x1           = 18'($urandom);
      x2           = 18'($urandom);
      restart      = ($urandom_range(0, 1499) == 0);
      cyc();
    end
    restart = 1'b0; sample_valid = 1'b0; wr_ack = 1'b1;
    wait_idle(1200);

    // Column wrap: more captures than columns
    max_x = 0;
    for (int i = 0; i <= TB_W; i++) begin
      capture_one(18'($urandom), 18'($urandom));
      wait_idle(600);
    end
    check("col_in_range", max_x < TB_W, 1);

    // Asynchronous reset mid-erase at row 200
    capture_one(18'h0_4000, 18'h3_C000);
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      if (w_en && vga_yCoord == 9'd200) found = 1;
      else cyc();
    end
    check("reach_row200", found, 1);
    #4 reset = 1'b1;
    #1;
    check("arst_w_en", w_en, 0);
    check("arst_busy", busy, 0);
    check("arst_xy", {vga_xCoord, vga_yCoord, vga_color}, 0);
    check("arst_dropped", dropped, 0);
    model_reset(0);
    @(posedge CLOCK_50); #1;
    reset = 1'b0;
    cyc();
    capture_one(18'h0_0000, 18'h0_0000);
    check("post_rst_start", {w_en, vga_xCoord, vga_yCoord}, {1'b1, 19'd0});
    wait_idle(600);

    // Restart coinciding with a capture stays idle
    restart = 1'b1; sample_valid = 1'b1; decim = 16'd1;
    cyc();
    check("restart_idle", busy, 0);
    restart = 1'b0; sample_valid = 1'b0;
    repeat (2) cyc();

    // Restart mid-strip keeps the drop count
    capture_one(18'h0_1000, 18'h0_2000);
    sample_valid = 1'b1;
    repeat (5) cyc();
    sample_valid = 1'b0;
    repeat (40) cyc();
    restart = 1'b1;
    cyc();
    restart = 1'b0;
    check("restart_keeps_drop", dropped, 5);
    capture_one(18'h0_0000, 18'h0_0000);
    wait_idle(600);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
